// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants.
// Holds NOP encoding, fetch defaults and fault-state enum.
package mips_pkg;

  localparam logic [31:0] MIPS_NOP           = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_IMEM_BYTES = 160;

  typedef enum logic {
    RUN,
    HALT
  } fault_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between fetch and imem.
// master: drives inst_addr, receives inst_data (comb).
interface fetch_stage_if;

  logic [31:0] inst_addr;
  logic [31:0] inst_data;

  modport master (
    output inst_addr,
    input  inst_data
  );

  modport slave (
    input  inst_addr,
    output inst_data
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble.
// Ports: clk, reset, load, bubble, instr_in/pc4_in -> instr/pc4/valid.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // bubble wins over load; pc4 is kept across a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= MIPS_NOP;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= MIPS_NOP;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage: pc, imem address, IF/ID capture,
// stall/redirect priority. Optional fault monitor: FETCH_FAULT_EN.
// Ports: clk, reset, imem (master), stall, redirect_valid/target,
// if_id_instr/pc4/valid, fetch_fault, fault_pc.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          MEM_BYTES = DEFAULT_IMEM_BYTES
) (
  input  logic           clk,
  input  logic           reset,
  fetch_stage_if.master  imem,
  input  logic           stall,
  input  logic           redirect_valid,
  input  logic [31:0]    redirect_target,
  output logic [31:0]    if_id_instr,
  output logic [31:0]    if_id_pc4,
  output logic           if_id_valid,
  output logic           fetch_fault,
  output logic [31:0]    fault_pc
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc4;
  logic        load;
  logic        bubble;
  logic        frozen;

  assign pc4            = pc + 32'd4;
  assign imem.inst_addr = pc;

`ifdef FETCH_FAULT_EN
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  fault_state_e state;
  fault_state_e state_next;
  logic [31:0]  fpc;
  logic         detect;

  assign detect = (pc[1:0] != 2'b00) || (pc > LAST_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fpc   <= '0;
    end else begin
      state <= state_next;
      if (state == RUN && detect)
        fpc <= pc;
    end
  end

  // faulting slot and every HALT cycle become bubbles
  always_comb begin
    state_next = state;
    frozen     = 1'b0;
    unique case (state)
      RUN: begin
        if (detect) begin
          state_next = HALT;
          frozen     = 1'b1;
        end
      end
      HALT: frozen = 1'b1;
      default: state_next = RUN;
    endcase
  end

  assign fetch_fault = (state == HALT);
  assign fault_pc    = fpc;
`else
  assign frozen      = 1'b0;
  assign fetch_fault = 1'b0;
  assign fault_pc    = '0;
`endif

  always_comb begin
    pc_next = pc;
    load    = 1'b0;
    bubble  = 1'b0;
    if (frozen) begin
      bubble = 1'b1;
    end else if (redirect_valid) begin
      // squash the wrong-path word now on inst_data
      pc_next = redirect_target;
      bubble  = 1'b1;
    end else if (!stall) begin
      pc_next = pc4;
      load    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .bubble   (bubble),
    .instr_in (imem.inst_data),
    .pc4_in   (pc4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit big-endian word into the IF/ID pipeline register. It sits between the PC-update logic (branch/jump redirects from decode) and the decode stage. It supports stall, redirect-with-squash and an optional address-fault monitor.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 160, instruction memory size in bytes; the last legal fetch address is MEM_BYTES-4.

Ports (clock and reset are listed first):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_addr  out  32  byte address to the instruction memory; combinational copy of pc.
- inst_data  in  32  word returned combinationally by the instruction memory for inst_addr.
- stall  in  1  hazard hold from decode; freezes pc and IF/ID.
- redirect_valid  in  1  taken branch or jump from decode.
- redirect_target  in  32  new PC, byte address.
- if_id_instr  out  32  registered instruction.
- if_id_pc4  out  32  registered pc+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- fetch_fault  out  1  sticky fault flag; present only with FETCH_FAULT_EN, otherwise tied to 0.
- fault_pc  out  32  offending address; present only with FETCH_FAULT_EN, otherwise tied to 0.

## Operation

- State is pc[31:0], the IF/ID register, and the fault state.
- Reset values:
  - pc = RESET_PC.
  - if_id_instr = NOP (32'h0).
  - if_id_pc4 = 0.
  - if_id_valid = 0.
  - fetch_fault = 0.
  - fault_pc = 0.
- Per-cycle priority, highest first:
  - **reset**: everything returns to its reset value.
  - **fault**: held once set.
  - **redirect_valid**:
    - pc <= redirect_target.
    - IF/ID <= bubble (instr = NOP, valid = 0, pc4 unchanged).
    - This squashes the wrong-path word currently being fetched.
    - A redirect overrides a simultaneous stall.
  - **stall**: pc and IF/ID hold their values.
  - **normal**:
    - IF/ID <= {inst_data, pc+4, valid = 1}.
    - pc <= pc+4.
- Arithmetic: pc+4 is 32-bit modulo; wrap-around from 32'hFFFF_FFFC to 0 is not trapped unless FETCH_FAULT_EN is defined.
- Fault state machine (FETCH_FAULT_EN only), two states:
  - **RUN**:
    - A fault is detected when pc[1:0] != 0, or when pc > MEM_BYTES-4, evaluated on the current pc.
    - On detection, move to HALT at the next edge:
      - fetch_fault <= 1.
      - fault_pc <= pc.
      - IF/ID <= bubble.
      - pc holds.
  - **HALT**:
    - pc frozen; IF/ID receives bubbles every cycle.
    - stall and redirect are ignored.
    - Exit only by reset.
- No instruction is ever issued from a faulting address: if_id_valid = 0 for that slot.

## Timing

- inst_addr equals pc combinationally (zero-cycle path into the memory).
- Fetch latency is 1 cycle: a word addressed in cycle N appears on if_id_instr after edge N+1.
- Redirect penalty is 1 bubble: after the redirect edge, IF/ID holds a bubble and pc = target; the target instruction appears in IF/ID one edge later.
- Stall: holds every cycle it is asserted; there is no stall-release latency.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). The first fetch of RESET_PC is captured at the first rising edge after reset deasserts.

## Configuration

- FETCH_FAULT_EN defined:
  - fetch_fault and fault_pc are live.
  - The RUN/HALT machine and the bounds/alignment compare are built.
- FETCH_FAULT_EN undefined:
  - Neither is built; both outputs are constant 0.
  - pc advances or redirects unconditionally; misaligned or out-of-range addresses go straight to the memory.

## Structure

- Shared package mips_pkg holds:
  - MIPS_NOP = 32'h0.
  - DEFAULT_RESET_PC.
  - DEFAULT_IMEM_BYTES = 160.
  - The fault-state enum {RUN, HALT}.
- One sub-module is natural: if_id_reg. It holds the IF/ID register with load, hold and bubble controls. fetch_stage owns pc, the priority logic and the fault machine.

## Test plan

- Reset release, no stall, memory holding words W0..W3 at 0,4,8,12 -> inst_addr steps 0,4,8,12; IF/ID shows {W0, pc4=4, valid=1}, then {W1, 8, 1}, and so on, one per cycle.
- Stall held high for 3 cycles while pc = 8 -> pc stays 8 and IF/ID holds {W1, 8, 1} for 3 cycles; W2 follows on the first edge after stall drops.
- redirect_valid with target 32'h40 while pc = 12 -> next cycle pc = 32'h40 and IF/ID is a bubble (valid=0, instr=0); the following cycle IF/ID = {mem[0x40], 32'h44, 1}.
- redirect_valid and stall asserted in the same cycle, target 32'h20 -> the redirect wins: pc = 32'h20 and IF/ID is a bubble.
- With FETCH_FAULT_EN, redirect to 32'h9E, then separately run to pc = 160 -> fetch_fault = 1, with fault_pc = 32'h9E (respectively 32'hA0); pc frozen and IF/ID bubbles until reset, after which fault = 0 and pc = 0.
- Assert reset mid-stream at pc = 32'h10 -> all outputs drop to reset values before the next edge; fetch resumes from 0.
